// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU wide-add engine.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_e;

    function automatic int chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder built from fulladder cells.
// c_msb exposes the carry into the top bit so the caller can form signed overflow.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder: CHUNK bits per clock, ripple carry held between chunks.
// Define MULTICYCLE_ADDER_SUB_EN to add a 'sub' port (x - y via x + ~y + 1).
module multicycle_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N     = chunks(WIDTH, CHUNK);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_chk
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    adder_state_e state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] x_q, y_q, y_eff;
    logic             c_eff;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             co_chunk, c_msb_chunk;

    // Subtract is folded into the captured B operand and carry-in.
`ifdef MULTICYCLE_ADDER_SUB_EN
    assign y_eff = sub ? ~y : y;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign y_eff = y;
    assign c_eff = cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_chunk = x_q[int'(idx)*CHUNK +: CHUNK];
    assign b_chunk = y_q[int'(idx)*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry),
        .sum   (sum_chunk),
        .co    (co_chunk),
        .c_msb (c_msb_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            x_q    <= x;
            y_q    <= y_eff;
            idx    <= '0;
            carry  <= c_eff;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == RUN) begin
            s_q[int'(idx)*CHUNK +: CHUNK] <= sum_chunk;
            carry <= co_chunk;
            idx   <= idx + IDX_W'(1);
            if (idx == LAST) begin
                cout_q <= co_chunk;
                ovf_q  <= c_msb_chunk ^ co_chunk;
            end
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder (WIDTH=8, CHUNK=2).
module tb_multicycle_adder;
    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] x = '0, y = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] s;

    multicycle_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .cin   (cin),
`ifdef MULTICYCLE_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, cyc = 0, rem = 0, ndone = 0;
    bit   fin = 0, chk_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sb_en, input int at);
        exp_t         e;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   r;
        bb = sb_en ? ~b : b;
        cc = sb_en ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
        e.s    = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.acc  = at;
        return e;
    endfunction

    // Reference protocol: rem counts chunk edges left; fin marks the done cycle.
    always @(posedge clk) begin
        logic sub_m;
`ifdef MULTICYCLE_ADDER_SUB_EN
        sub_m = sub;
`else
        sub_m = 1'b0;
`endif
        cyc++;
        fin = 0;
        if (rst) begin
            rem = 0;
            sb.delete();
        end else if (rem == 0 && start) begin
            sb.push_back(model(x, y, cin, sub_m, cyc));
            rem = N;
        end else if (rem > 0) begin
            rem--;
            fin = (rem == 0);
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_en) begin
            chk("busy", busy, rem != 0);
            chk("done", done, fin);
            if (done) begin
                ndone++;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("s", s, e.s);
                    chk("cout", cout, e.cout);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc - e.acc, N);
                end
            end
        end
    end

    task automatic wait_free();
        int k = 0;
        while (rem != 0 && k < 4 * N) begin
            @(posedge clk); #1;
            k++;
        end
        if (rem != 0) chk("wait_free_timeout", 1, 0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic sb_en);
        int d0;
        wait_free();
        d0 = ndone;
        x = a; y = b; cin = c; sub = sb_en; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N + 1) @(posedge clk);
        #1;
        chk("op_done_count", ndone - d0, 1);
    endtask

    initial begin
        int d0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;

        op(W'('h0F), W'('h01), 1'b0, 1'b0);
        chk("dir1_s", s, 'h10);
        chk("dir1_cout", cout, 0);
        op(W'('hFF), W'('h01), 1'b1, 1'b0);
        chk("dir2_s", s, 'h01);
        chk("dir2_cout", cout, 1);
        chk("dir2_ovf", ovf, 0);
        op(W'('h7F), W'('h01), 1'b0, 1'b0);
        chk("dir3_s", s, 'h80);
        chk("dir3_ovf", ovf, 1);

        // start held high, operands churned every cycle including mid-RUN
        wait_free();
        d0 = ndone;
        start = 1'b1;
        for (int i = 0; i < 6 * (N + 1); i++) begin
            x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        chk("b2b_count", ndone - d0, 6);

        // reset during the second RUN cycle aborts silently
        wait_free();
        d0 = ndone;
        x = W'('h5A); y = W'('h3C); cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s", s, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        repeat (N + 2) @(posedge clk);
        #1;
        chk("abort_no_done", ndone - d0, 0);
        op(W'('hA5), W'('h5B), 1'b1, 1'b0);

        // random traffic with random start gaps
        for (int i = 0; i < 5000; i++) begin
            start = 1'($urandom);
            x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
`ifdef MULTICYCLE_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            @(posedge clk); #1;
        end
        start = 1'b0;
        sub   = 1'b0;

`ifdef MULTICYCLE_ADDER_SUB_EN
        op(W'('h05), W'('h07), 1'b0, 1'b1);
        chk("sub1_s", s, 'hFE);
        chk("sub1_cout", cout, 0);
        op(W'('h80), W'('h01), 1'b0, 1'b1);
        chk("sub2_s", s, 'h7F);
        chk("sub2_ovf", ovf, 1);
`endif

        wait_free();
        repeat (N + 2) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
